// File: rtl/rx_channel.sv
// DUART channel receiver: 16x-oversampled async RxD into a 3-entry holding FIFO
// carrying {FE, PE, data}, with RxRDY / FFULL / sticky OVERRUN status.
module rx_channel #(
  parameter int FIFO_DEPTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       RxReset,
  input  logic       RxD,
  input  logic       baud_x16,
  input  logic       RxEN,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       rhr_cs,
  input  logic       r_w,
  input  logic       err_reset,
  output logic [7:0] rx_data,
  output logic       RxRDY,
  output logic       FFULL,
  output logic       OVERRUN,
  output logic       PE,
  output logic       FE
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic f_parity_err(input logic [7:0] d, input logic p, input logic odd);
    return (^{d, p}) != odd;
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_tick, w_tick_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_pe, w_pe_nxt;
  logic        w_push, w_fe;
  logic [9:0]  w_push_data;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic          r_rd_armed, r_overrun;
  logic          w_rd_access, w_pop, w_push_ok, w_overrun_ev;
  logic [9:0]    w_head_nxt;

  // RxD synchroniser
  always_ff @(posedge clk) begin
    if (!RxReset) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], RxD};
  end

  assign w_rxd = r_sync[SYNC_STAGES-1];

  // Frame FSM
  always_ff @(posedge clk) begin
    if (!RxReset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
    end
    r_shift <= w_shift_nxt;
    r_pe    <= w_pe_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pe_nxt    = r_pe;
    w_push      = 1'b0;
    w_fe        = 1'b0;
    if (!RxEN) begin
      w_state_nxt = S_IDLE;
    end else if (baud_x16) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxd) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick == 4'd7) begin
            w_tick_nxt = '0;
            if (w_rxd) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
              w_pe_nxt    = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
        S_DATA: begin
          w_tick_nxt = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_shift_nxt = {w_rxd, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = parity_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          w_tick_nxt = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_pe_nxt    = f_parity_err(r_shift, w_rxd, parity_odd);
            w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          w_tick_nxt = r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            w_push      = 1'b1;
            w_fe        = ~w_rxd;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_push_data = {w_fe, r_pe, r_shift};

  // Holding FIFO: a pop in the same clk as a push into a full FIFO makes room for it
  assign w_rd_access  = rhr_cs & r_w;
  assign w_pop        = w_rd_access & r_rd_armed & (r_count != '0);
  assign w_push_ok    = w_push & ((r_count != DEPTH_C) | w_pop);
  assign w_overrun_ev = w_push & ~w_push_ok;
  assign w_count_nxt  = r_count + CW'(w_push_ok) - CW'(w_pop);
  assign w_rd_ptr_nxt = w_pop ? f_ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_head_nxt   = (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) ? w_push_data
                                                                  : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (RxReset && w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!RxReset) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_armed <= 1'b1;
      r_overrun  <= 1'b0;
      RxRDY      <= 1'b0;
      FFULL      <= 1'b0;
      rx_data    <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_push_ok ? f_ptr_inc(r_wr_ptr) : r_wr_ptr;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_rd_armed <= ~w_rd_access;
      if (w_overrun_ev)   r_overrun <= 1'b1;
      else if (err_reset) r_overrun <= 1'b0;
      RxRDY <= (w_count_nxt != '0);
      FFULL <= (w_count_nxt == DEPTH_C);
      if (w_count_nxt != '0) {FE, PE, rx_data} <= w_head_nxt;
    end
  end

  assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_rx_channel.sv
// Directed bench for rx_channel: framing, parity, FIFO full/overrun, read-edge pop, reset.
module tb_rx_channel;

  logic       clk = 1'b0;
  logic       RxReset, RxD, baud_x16, RxEN, parity_en, parity_odd;
  logic       rhr_cs, r_w, err_reset;
  logic [7:0] rx_data;
  logic       RxRDY, FFULL, OVERRUN, PE, FE;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic lat_before, lat_after;

  rx_channel #(.FIFO_DEPTH(3), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .RxReset   (RxReset),
    .RxD       (RxD),
    .baud_x16  (baud_x16),
    .RxEN      (RxEN),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rhr_cs    (rhr_cs),
    .r_w       (r_w),
    .err_reset (err_reset),
    .rx_data   (rx_data),
    .RxRDY     (RxRDY),
    .FFULL     (FFULL),
    .OVERRUN   (OVERRUN),
    .PE        (PE),
    .FE        (FE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns on a negedge. Stop mid-sample lands on the 11th clk of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input logic rd_at_push);
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (16) @(negedge clk);
    end
    if (pen) begin
      RxD = pbit;
      repeat (16) @(negedge clk);
    end
    RxD = stop;
    repeat (10) @(negedge clk);
    lat_before = RxRDY;
    if (rd_at_push) begin
      rhr_cs = 1'b1;
      r_w    = 1'b1;
    end
    @(negedge clk);
    lat_after = RxRDY;
    repeat (4) @(negedge clk);
    rhr_cs = 1'b0;
    r_w    = 1'b0;
    @(negedge clk);
    RxD = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic rd_access();
    rhr_cs = 1'b1;
    r_w    = 1'b1;
    @(negedge clk);
    rhr_cs = 1'b0;
    r_w    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    RxReset = 1'b0; RxD = 1'b1; baud_x16 = 1'b1; RxEN = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; rhr_cs = 1'b0; r_w = 1'b0; err_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_rdy", {7'd0, RxRDY}, 8'd0);
    chk("rst_ffull", {7'd0, FFULL}, 8'd0);
    chk("rst_ovr", {7'd0, OVERRUN}, 8'd0);
    chk("rst_pe", {7'd0, PE}, 8'd0);
    chk("rst_fe", {7'd0, FE}, 8'd0);
    RxReset = 1'b1;
    repeat (4) @(negedge clk);

    // single character, latency and pop
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_lat_before", {7'd0, lat_before}, 8'd0);
    chk("a5_lat_after", {7'd0, lat_after}, 8'd1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_pe", {7'd0, PE}, 8'd0);
    chk("a5_fe", {7'd0, FE}, 8'd0);
    rd_access();
    chk("a5_rdy_after_rd", {7'd0, RxRDY}, 8'd0);

    // fill, overrun, drain in order
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fill2_ffull", {7'd0, FFULL}, 8'd0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fill3_ffull", {7'd0, FFULL}, 8'd1);
    chk("fill3_ovr", {7'd0, OVERRUN}, 8'd0);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_set", {7'd0, OVERRUN}, 8'd1);
    chk("ovr_ffull", {7'd0, FFULL}, 8'd1);
    chk("rd1_data", rx_data, 8'h11);
    rd_access();
    chk("rd2_data", rx_data, 8'h22);
    chk("rd2_ffull", {7'd0, FFULL}, 8'd0);
    rd_access();
    chk("rd3_data", rx_data, 8'h33);
    rd_access();
    chk("drained_rdy", {7'd0, RxRDY}, 8'd0);
    chk("drained_hold", rx_data, 8'h33);
    chk("ovr_sticky", {7'd0, OVERRUN}, 8'd1);
    err_reset = 1'b1;
    @(negedge clk);
    err_reset = 1'b0;
    chk("ovr_cleared", {7'd0, OVERRUN}, 8'd0);

    // odd parity
    parity_en = 1'b1; parity_odd = 1'b1;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_bad_pe", {7'd0, PE}, 8'd1);
    chk("par_bad_data", rx_data, 8'h03);
    rd_access();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("par_good_pe", {7'd0, PE}, 8'd0);
    chk("par_good_rdy", {7'd0, RxRDY}, 8'd1);
    rd_access();
    parity_en = 1'b0; parity_odd = 1'b0;

    // framing error, then a short glitch that must not push
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fe_flag", {7'd0, FE}, 8'd1);
    chk("fe_data", rx_data, 8'h7E);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_rdy", {7'd0, RxRDY}, 8'd1);
    chk("glitch_data", rx_data, 8'h7E);
    rd_access();
    chk("glitch_nopush", {7'd0, RxRDY}, 8'd0);

    // full FIFO, held read coincident with push
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("popush_ovr", {7'd0, OVERRUN}, 8'd0);
    chk("popush_ffull", {7'd0, FFULL}, 8'd1);
    chk("popush_head", rx_data, 8'h02);
    rd_access();
    chk("popush_e2", rx_data, 8'h03);
    rd_access();
    chk("popush_e3", rx_data, 8'h04);
    rd_access();
    chk("popush_empty", {7'd0, RxRDY}, 8'd0);

    // reset mid-character with two entries queued and OVERRUN set
    send_frame(8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    rd_access();
    chk("pre_rst_head", rx_data, 8'h20);
    chk("pre_rst_ovr", {7'd0, OVERRUN}, 8'd1);
    RxD = 1'b0;
    repeat (40) @(negedge clk);
    RxReset = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", {7'd0, RxRDY}, 8'd0);
    chk("midrst_ffull", {7'd0, FFULL}, 8'd0);
    chk("midrst_ovr", {7'd0, OVERRUN}, 8'd0);
    chk("midrst_data", rx_data, 8'h00);
    RxReset = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_rdy", {7'd0, RxRDY}, 8'd1);
    chk("post_rst_ffull", {7'd0, FFULL}, 8'd0);
    chk("post_rst_fe", {7'd0, FE}, 8'd0);
    rd_access();
    chk("post_rst_empty", {7'd0, RxRDY}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
